// File: rtl/ahb_bus_matrix_slv_sram.sv
// AHB-Lite SRAM responder for a bus-matrix output port: programmable wait states,
// byte-lane writes and a two-cycle ERROR response for illegal accesses.
module ahb_bus_matrix_slv_sram #(
   parameter int AW          = 10,
   parameter int WAIT_STATES = 1,
   parameter int WPROT_USER  = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [3:0]  HPROT,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int         DEPTH     = 1 << AW;
   localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LAST,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t          state_reg, state_next;
   logic [2:0]      cnt_reg, cnt_next;
   logic [AW-1:0]   waddr_reg;
   logic [1:0]      lsb_reg;
   logic [2:0]      size_reg;
   logic            write_reg;

   logic            can_accept;
   logic            accept;
   logic            addr_err;
   logic            mem_we;
   logic [3:0]      lane_en;
   logic [31:0]     rd_word;
   logic            unused_bits;

   assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0], HPROT[3:2], HPROT[0]};

   // A new address phase can only be taken while the bus sees us ready.
   assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_LAST) || (state_reg == ST_ERR2);
   assign accept     = can_accept & HSEL & HTRANS[1] & HREADY;

   assign addr_err = (HSIZE > 3'b010)
                   | ((HSIZE == 3'b001) & HADDR[0])
                   | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00))
                   | (HWRITE & (WPROT_USER != 0) & ~HPROT[1]);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 3'd0;
         waddr_reg <= '0;
         lsb_reg   <= 2'd0;
         size_reg  <= 3'd0;
         write_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            waddr_reg <= HADDR[AW+1:2];
            lsb_reg   <= HADDR[1:0];
            size_reg  <= HSIZE;
            write_reg <= HWRITE;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      HREADYOUT  = 1'b1;
      HRESP      = 1'b0;
      case (state_reg)
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            if (cnt_reg == 3'd0) begin
               state_next = ST_LAST;
            end else begin
               cnt_next = cnt_reg - 3'd1;
            end
         end
         ST_ERR1: begin
            HREADYOUT  = 1'b0;
            HRESP      = 1'b1;
            state_next = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP = 1'b1;
         end
         default: ;
      endcase
      // IDLE, LAST and ERR2 all branch identically on a (possibly pipelined) address phase.
      if (can_accept) begin
         if (!accept) begin
            state_next = ST_IDLE;
         end else if (addr_err) begin
            state_next = ST_ERR1;
         end else if (WAIT_STATES == 0) begin
            state_next = ST_LAST;
         end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
         end
      end
   end

   // Writes land on the edge that ends the last data cycle, so a reset on that edge drops them.
   assign mem_we = ~HRESET & (state_reg == ST_LAST) & write_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];

         assign lane_en[gi] = (size_reg == 3'd0) ? (lsb_reg == 2'(gi)) :
                              (size_reg == 3'd1) ? (lsb_reg[1] == 1'(gi >> 1)) :
                              1'b1;

         always_ff @(posedge HCLK) begin
            if (mem_we && lane_en[gi]) begin
               mem[waddr_reg] <= HWDATA[8*gi +: 8];
            end
         end

         assign rd_word[8*gi +: 8] = mem[waddr_reg];
      end
   endgenerate

   assign HRDATA = ((state_reg == ST_LAST) && !write_reg) ? rd_word : 32'd0;

endmodule
